// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and defaults for the single-port RAM arbiter
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_t;

    // One slot of the read-return tracking pipe
    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_entry_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin picker, purely combinational
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_t    ptr,
    output logic [1:0] grant,
    output req_id_t    next_ptr
);

    // Tie goes to the pointer and flips it; a lone request is granted without touching the pointer
    always_comb begin
        grant    = valid;
        next_ptr = ptr;
        if (valid == 2'b11) begin
            if (ptr == REQ0) begin
                grant    = 2'b01;
                next_ptr = REQ1;
            end else begin
                grant    = 2'b10;
                next_ptr = REQ0;
            end
        end
    end

endmodule

// File: rtl/ram_sp_arbiter.sv
// rtl/ram_sp_arbiter.sv - shares one single-port RAM between two requesters
module ram_sp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ack,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ack,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    req_id_t           prio;
    req_id_t           prio_next;
    logic [1:0]        grant;
    logic              acc;
    req_id_t           acc_id;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    rd_entry_t         rd_new;
    rd_entry_t [RD_LAT:0] rd_pipe;

    rr_arb2 u_rr_arb2 (
        .valid    ({req1_valid, req0_valid}),
        .ptr      (prio),
        .grant    (grant),
        .next_ptr (prio_next)
    );

    // Acks are suppressed during reset so nothing is accepted into a clearing pipeline
    always_comb begin
        req0_ack  = grant[0] & ~sys_rst;
        req1_ack  = grant[1] & ~sys_rst;
        acc       = req0_ack | req1_ack;
        acc_id    = req1_ack ? REQ1 : REQ0;
        acc_we    = req1_ack ? req1_we    : req0_we;
        acc_addr  = req1_ack ? req1_addr  : req0_addr;
        acc_wdata = req1_ack ? req1_wdata : req0_wdata;
        rd_new    = '{valid: acc & ~acc_we, id: acc_id};
    end

    // Priority pointer; the picker only moves it on a tie
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            prio <= REQ0;
        end else begin
            prio <= prio_next;
        end
    end

    // RAM command register; address and write data hold when idle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wr_data <= '0;
        end else if (acc) begin
            ram_en      <= 1'b1;
            ram_we      <= acc_we;
            ram_addr    <= acc_addr;
            ram_wr_data <= acc_wdata;
        end else begin
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
        end
    end

    // Read tracking: stage k is visible k+1 cycles after acceptance, so the last stage lines up with douta
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rd_pipe <= '0;
        end else begin
            rd_pipe <= {rd_pipe[RD_LAT-1:0], rd_new};
        end
    end

    // Steer the RAM output to whichever requester owns the returning read
    always_comb begin
        rd0_valid = rd_pipe[RD_LAT].valid && (rd_pipe[RD_LAT].id == REQ0);
        rd1_valid = rd_pipe[RD_LAT].valid && (rd_pipe[RD_LAT].id == REQ1);
        rd0_data  = ram_rd_data;
        rd1_data  = ram_rd_data;
    end

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// tb/tb_ram_sp_arbiter.sv - directed self-checking bench for ram_sp_arbiter
module tb_ram_sp_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;

    logic              sys_clk = 1'b0;
    logic              sys_rst = 1'b1;
    logic              req0_valid = 1'b0, req0_we = 1'b0;
    logic [ADDR_W-1:0] req0_addr = '0;
    logic [DATA_W-1:0] req0_wdata = '0;
    logic              req0_ack, rd0_valid;
    logic [DATA_W-1:0] rd0_data;
    logic              req1_valid = 1'b0, req1_we = 1'b0;
    logic [ADDR_W-1:0] req1_addr = '0;
    logic [DATA_W-1:0] req1_wdata = '0;
    logic              req1_ack, rd1_valid;
    logic [DATA_W-1:0] rd1_data;
    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic [DATA_W-1:0] ram_rd_data;

    int vectors = 0;
    int miscompares = 0;

    always #5 sys_clk = ~sys_clk;

    ram_sp_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ack(req0_ack), .rd0_valid(rd0_valid), .rd0_data(rd0_data),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ack(req1_ack), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_data(ram_rd_data)
    );

    // Block RAM model with two-cycle read latency; preloaded with 0x80+addr
    logic [DATA_W-1:0] mem [32];
    logic [DATA_W-1:0] d1, d2;
    logic              mem_init = 1'b1;
    always @(posedge sys_clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h80 + 8'(i);
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wr_data;
            else        d1 <= mem[ram_addr];
        end
        d2 <= d1;
    end
    assign ram_rd_data = d2;

    // Contents after the single-writer and RAW tests have run
    function automatic logic [7:0] exp_mem(input int a);
        if (a == 3)  return 8'hA5;
        if (a == 31) return 8'h3C;
        return 8'h80 + 8'(a);
    endfunction

    task automatic idle();
        req0_valid = 1'b0; req0_we = 1'b0;
        req1_valid = 1'b0; req1_we = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge sys_clk);
        mem_init = 1'b0;
        req0_valid = 1'b1; req0_addr = 5'd4;
        req1_valid = 1'b1; req1_addr = 5'd7;
        #1;
        vectors++; if (req0_ack !== 1'b0 || req1_ack !== 1'b0) begin miscompares++; $display("FAIL rst_acks: got %b%b expected 00", req1_ack, req0_ack); end
        vectors++; if ({ram_en, ram_we} !== 2'b00) begin miscompares++; $display("FAIL rst_en_we: got %b expected 00", {ram_en, ram_we}); end
        vectors++; if (ram_addr !== 5'd0 || ram_wr_data !== 8'd0) begin miscompares++; $display("FAIL rst_addr_data: got %h/%h expected 00/00", ram_addr, ram_wr_data); end
        vectors++; if ({rd1_valid, rd0_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_rd_valid: got %b expected 00", {rd1_valid, rd0_valid}); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1;
        vectors++; if (req0_ack !== 1'b1 || req1_ack !== 1'b0) begin miscompares++; $display("FAIL first_tie: got ack1/ack0 %b%b expected 01", req1_ack, req0_ack); end
        @(negedge sys_clk);
        idle();
        #1;
        vectors++; if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 5'd4) begin miscompares++; $display("FAIL first_issue: got en %b we %b addr %h expected 1 0 04", ram_en, ram_we, ram_addr); end
        sys_rst = 1'b1;
        #1;
        vectors++; if (ram_en !== 1'b0 || ram_addr !== 5'd0 || {rd1_valid, rd0_valid} !== 2'b00) begin miscompares++; $display("FAIL midstream_rst: got en %b addr %h rdv %b expected 0 00 00", ram_en, ram_addr, {rd1_valid, rd0_valid}); end
        @(negedge sys_clk);
        sys_rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge sys_clk); #1;
            vectors++; if ({rd1_valid, rd0_valid} !== 2'b00) begin miscompares++; $display("FAIL midstream_drop: cycle %0d got %b expected 00", k, {rd1_valid, rd0_valid}); end
        end
    endtask

    task automatic test_single_write();
        @(negedge sys_clk);
        req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 5'd3; req0_wdata = 8'hA5;
        #1;
        vectors++; if (req0_ack !== 1'b1 || req1_ack !== 1'b0) begin miscompares++; $display("FAIL wr_ack: got %b%b expected 01", req1_ack, req0_ack); end
        @(negedge sys_clk);
        idle();
        #1;
        vectors++; if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 5'd3 || ram_wr_data !== 8'hA5) begin miscompares++; $display("FAIL wr_issue: got en/we %b addr %h data %h expected 11 03 a5", {ram_en, ram_we}, ram_addr, ram_wr_data); end
        @(negedge sys_clk); #1;
        vectors++; if ({ram_en, ram_we} !== 2'b00 || ram_addr !== 5'd3 || ram_wr_data !== 8'hA5) begin miscompares++; $display("FAIL wr_hold: got en/we %b addr %h data %h expected 00 03 a5", {ram_en, ram_we}, ram_addr, ram_wr_data); end
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk); #1;
            vectors++; if ({rd1_valid, rd0_valid} !== 2'b00) begin miscompares++; $display("FAIL wr_no_rd: cycle %0d got %b expected 00", k, {rd1_valid, rd0_valid}); end
        end
    endtask

    task automatic test_tie();
        for (int k = 0; k < 8; k++) begin
            logic e0, e1, r0, r1;
            @(negedge sys_clk);
            if (k < 4) begin
                req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd1;
                req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd2;
            end else idle();
            #1;
            e0 = (k < 4) && (k % 2 == 0);
            e1 = (k < 4) && (k % 2 == 1);
            r0 = (k >= 3) && (k <= 6) && ((k - 3) % 2 == 0);
            r1 = (k >= 3) && (k <= 6) && ((k - 3) % 2 == 1);
            vectors++; if (req0_ack !== e0 || req1_ack !== e1) begin miscompares++; $display("FAIL tie_ack: cycle %0d got %b%b expected %b%b", k, req1_ack, req0_ack, e1, e0); end
            vectors++; if (rd0_valid !== r0 || rd1_valid !== r1) begin miscompares++; $display("FAIL tie_rdv: cycle %0d got %b%b expected %b%b", k, rd1_valid, rd0_valid, r1, r0); end
            if (r0) begin vectors++; if (rd0_data !== 8'h81) begin miscompares++; $display("FAIL tie_rd0_data: cycle %0d got %h expected 81", k, rd0_data); end end
            if (r1) begin vectors++; if (rd1_data !== 8'h82) begin miscompares++; $display("FAIL tie_rd1_data: cycle %0d got %h expected 82", k, rd1_data); end end
        end
    endtask

    task automatic test_raw();
        for (int k = 0; k < 6; k++) begin
            logic e0, e1, r0;
            @(negedge sys_clk);
            idle();
            if (k == 0) begin req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 5'd31; req1_wdata = 8'h3C; end
            if (k == 1) begin req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd31; end
            #1;
            e0 = (k == 1); e1 = (k == 0); r0 = (k == 4);
            vectors++; if (req0_ack !== e0 || req1_ack !== e1) begin miscompares++; $display("FAIL raw_ack: cycle %0d got %b%b expected %b%b", k, req1_ack, req0_ack, e1, e0); end
            vectors++; if (rd0_valid !== r0 || rd1_valid !== 1'b0) begin miscompares++; $display("FAIL raw_rdv: cycle %0d got %b%b expected 0%b", k, rd1_valid, rd0_valid, r0); end
            if (r0) begin vectors++; if (rd0_data !== 8'h3C) begin miscompares++; $display("FAIL raw_data: got %h expected 3c", rd0_data); end end
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        for (int k = 0; k < 36; k++) begin
            logic r0;
            @(negedge sys_clk);
            idle();
            if (k < 32) begin req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'(k); end
            #1;
            r0 = (k >= 3) && (k < 35);
            if (rd0_valid === 1'b1) pulses++;
            vectors++; if (req0_ack !== (k < 32) || req1_ack !== 1'b0) begin miscompares++; $display("FAIL b2b_ack: cycle %0d got %b%b expected 0%b", k, req1_ack, req0_ack, (k < 32)); end
            vectors++; if (rd0_valid !== r0 || rd1_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_rdv: cycle %0d got %b%b expected 0%b", k, rd1_valid, rd0_valid, r0); end
            if (r0) begin vectors++; if (rd0_data !== exp_mem(k - 3)) begin miscompares++; $display("FAIL b2b_data: addr %0d got %h expected %h", k - 3, rd0_data, exp_mem(k - 3)); end end
        end
        vectors++; if (pulses != 32) begin miscompares++; $display("FAIL b2b_count: got %0d expected 32", pulses); end
    endtask

    task automatic test_reset_inflight();
        @(negedge sys_clk);
        req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 5'd5;
        #1;
        vectors++; if (req0_ack !== 1'b1) begin miscompares++; $display("FAIL inflight_ack0: got %b expected 1", req0_ack); end
        @(negedge sys_clk);
        idle();
        req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 5'd6;
        #1;
        vectors++; if (req1_ack !== 1'b1) begin miscompares++; $display("FAIL inflight_ack1: got %b expected 1", req1_ack); end
        @(negedge sys_clk);
        idle();
        req0_valid = 1'b1; req0_addr = 5'd9;
        sys_rst = 1'b1;
        #1;
        vectors++; if ({req1_ack, req0_ack} !== 2'b00) begin miscompares++; $display("FAIL inflight_rst_acks: got %b expected 00", {req1_ack, req0_ack}); end
        vectors++; if (ram_en !== 1'b0 || ram_addr !== 5'd0 || {rd1_valid, rd0_valid} !== 2'b00) begin miscompares++; $display("FAIL inflight_rst_out: got en %b addr %h rdv %b expected 0 00 00", ram_en, ram_addr, {rd1_valid, rd0_valid}); end
        @(negedge sys_clk);
        idle();
        sys_rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sys_clk); #1;
            vectors++; if ({rd1_valid, rd0_valid} !== 2'b00) begin miscompares++; $display("FAIL inflight_drop: cycle %0d got %b expected 00", k, {rd1_valid, rd0_valid}); end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_tie();
        test_raw();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
